// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte transmitter: widths, line idle level,
// FSM state encoding and the parity helper.
package uart_pkg;

    localparam int   DATA_W     = 8;
    localparam int   BIT_CNT_W  = 3;
    localparam logic IDLE_LEVEL = 1'b1;

    // PARITY is only entered when the parity option is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while En is high and pulses Tick in
// the last clock of each bit period. Held at zero while En is low so the first
// bit of a frame always gets its full length.
module uart_baud_gen #(
    parameter int BAUD_DIV = 5208
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    output logic Tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Free-running bit-period counter, cleared whenever the line is idle.
    // NOTE: sequential state is assigned with <= so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst || !En) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign Tick = En && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: one byte per Send_en strobe, 8N1 framing, LSB first,
// with a one-entry holding register for a request that arrives mid-frame.
// Define UART_TX_PARITY_EN to insert an odd parity bit after data bit 7 (8O1).
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Data_byte,
    input  logic              Send_en,
    output logic              Rs232_Tx,
    output logic              Tx_Done,
    output logic              uart_state,
    output logic              Overrun
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;

    tx_state_e             state_q, state_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic                  busy;
    logic                  tick;
    logic                  tx_done;
    logic                  overrun;
    logic                  load;
    logic [DATA_W-1:0]     load_byte;

    assign busy = (state_q != ST_IDLE);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .Clk  (Clk),
        .Rst  (Rst),
        .En   (busy),
        .Tick (tick)
    );

    // Next-state logic: frame sequencing, holding-register capture and frame loading.
    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        tx_d         = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif
        load         = 1'b0;
        load_byte    = Data_byte;
        overrun      = 1'b0;
        tx_done      = (state_q == ST_STOP) && tick;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = IDLE_LEVEL;
                if (Send_en) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = IDLE_LEVEL;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = IDLE_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    // Chain straight into the next START: no extra idle bit.
                    if (hold_valid_q) begin
                        load         = 1'b1;
                        load_byte    = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (Send_en) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase

        // A request while busy (including the Tx_Done clock) is held or dropped.
        if (busy && Send_en) begin
            if (hold_valid_q) begin
                overrun = 1'b1;
            end else if (!tx_done) begin
                hold_d       = Data_byte;
                hold_valid_d = 1'b1;
            end
        end

        if (load) begin
            state_d   = ST_START;
            shift_d   = load_byte;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d     = odd_parity(load_byte);
`endif
        end
    end

    // State, datapath and line registers; reset wins over every other input.
    // NOTE: shift and holding data need no reset: they are only read after a
    // load or while hold_valid_q is set, so only the control bits are reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            tx_q         <= IDLE_LEVEL;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
        end
    end

    // Data registers, loaded without reset.
    always_ff @(posedge Clk) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign Rs232_Tx   = tx_q;
    assign uart_state = busy;
    assign Tx_Done    = tx_done && !Rst;
    assign Overrun    = overrun && !Rst;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: directed scenarios plus random traffic,
// compared every clock against a frame-level timeline model.
module tb_uart_byte_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * DIV;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] Data_byte = 8'h00;
    logic       Send_en = 1'b0;
    logic       Rs232_Tx, Tx_Done, uart_state, Overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_done = 0;
    int n_ovr  = 0;

    // Model: a frame is a start cycle plus a byte; the line is derived from the offset.
    bit         m_active = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_hold_v = 1'b0;
    logic [7:0] m_hold   = 8'h00;

    always #5 clk = ~clk;

    uart_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .Clk        (clk),
        .Rst        (Rst),
        .Data_byte  (Data_byte),
        .Send_en    (Send_en),
        .Rs232_Tx   (Rs232_Tx),
        .Tx_Done    (Tx_Done),
        .uart_state (uart_state),
        .Overrun    (Overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Bit idx of a frame: start, data LSB first, optional odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(b[i]);
            return (ones % 2 == 0) ? 1'b1 : 1'b0;
        end
`endif
        return 1'b1;
    endfunction

    // One clock: drive inputs after the edge, compare mid-cycle, advance the model.
    task automatic step(input logic s, input logic [7:0] d, input logic r);
        logic [3:0] exp, got;
        int  off;
        bit  done, hv;
        @(posedge clk);
        #1;
        Send_en   = s;
        Data_byte = d;
        Rst       = r;
        @(negedge clk);
        cyc++;
        exp  = 4'b1000;
        off  = 0;
        done = 1'b0;
        if (m_active) begin
            off    = cyc - m_start;
            done   = (off == FL - 1);
            exp[3] = frame_bit(m_byte, off / DIV);
            exp[2] = 1'b1;
            exp[1] = done && !r;
        end
        exp[0] = s && m_active && m_hold_v && !r;
        got = {Rs232_Tx, uart_state, Tx_Done, Overrun};
        check("tx/state/done/ovr", {28'd0, got}, {28'd0, exp});
        n_done += int'(Tx_Done);
        n_ovr  += int'(Overrun);

        hv = m_hold_v;
        if (r) begin
            m_active = 1'b0;
            m_hold_v = 1'b0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_start  = cyc + 1;
                m_byte   = d;
            end
        end else if (done) begin
            if (hv) begin
                m_start  = cyc + 1;
                m_byte   = m_hold;
                m_hold_v = 1'b0;
            end else if (s) begin
                m_start = cyc + 1;
                m_byte  = d;
            end else begin
                m_active = 1'b0;
            end
        end else if (s && !hv) begin
            m_hold_v = 1'b1;
            m_hold   = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int done_at;

        // Power-up reset; outputs are unknown before the first reset edge.
        repeat (2) @(posedge clk);
        step(1'b0, 8'h00, 1'b1);
        check("reset_tx", {31'd0, Rs232_Tx}, 32'd1);
        check("reset_state", {31'd0, uart_state}, 32'd0);
        idle(3);

        // Single 0x55 frame from idle; Tx_Done in its last clock.
        step(1'b1, 8'h55, 1'b0);
        done_at = 0;
        for (int i = 1; i <= FL + 5; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (Tx_Done && done_at == 0) done_at = i;
        end
        check("done_at_clk", done_at, FL);

        // 0xA3 then 0x0F five clocks later: back-to-back frames, no overrun.
        n_done = 0;
        n_ovr  = 0;
        step(1'b1, 8'hA3, 1'b0);
        idle(4);
        step(1'b1, 8'h0F, 1'b0);
        idle(2 * FL + 10);
        check("b2b_frames", n_done, 2);
        check("b2b_overrun", n_ovr, 0);

        // Three requests inside one frame: second held, third dropped.
        n_done = 0;
        n_ovr  = 0;
        step(1'b1, 8'h3C, 1'b0);
        idle(9);
        step(1'b1, 8'hC3, 1'b0);
        idle(9);
        step(1'b1, 8'h99, 1'b0);
        idle(3 * FL);
        check("three_frames", n_done, 2);
        check("three_overrun", n_ovr, 1);

        // Reset at clock 45 of a 0xFF frame with a byte waiting in holding.
        n_done = 0;
        step(1'b1, 8'hFF, 1'b0);
        idle(19);
        step(1'b1, 8'h81, 1'b0);
        idle(24);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("rst_mid_tx", {31'd0, Rs232_Tx}, 32'd1);
        check("rst_mid_state", {31'd0, uart_state}, 32'd0);
        idle(2 * FL);
        check("rst_no_done", n_done, 0);

        // Request in the Tx_Done clock starts the next frame on the next clock.
        n_done = 0;
        step(1'b1, 8'hC6, 1'b0);
        idle(FL - 1);
        step(1'b1, 8'h5A, 1'b0);
        check("coinc_done", {31'd0, Tx_Done}, 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("coinc_start_tx", {31'd0, Rs232_Tx}, 32'd0);
        check("coinc_start_state", {31'd0, uart_state}, 32'd1);
        idle(FL + 5);
        check("coinc_frames", n_done, 2);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: odd parity bit 0, Tx_Done at clock 110.
        step(1'b1, 8'h07, 1'b0);
        done_at = 0;
        for (int i = 1; i <= FL + 5; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (i == 9 * DIV + DIV / 2) check("parity_bit", {31'd0, Rs232_Tx}, 32'd0);
            if (Tx_Done && done_at == 0) done_at = i;
        end
        check("parity_done_at", done_at, 110);
`endif

        // Random traffic with varying request density and rare resets.
        for (int e = 0; e < 4; e++) begin
            int rate = (e == 0) ? 200 : (e == 1) ? 60 : (e == 2) ? 25 : 8;
            for (int i = 0; i < 1000; i++) begin
                logic s, r;
                s = ($urandom_range(0, rate - 1) == 0);
                r = ($urandom_range(0, 799) == 0);
                step(s, 8'($urandom_range(0, 255)), r);
            end
        end
        idle(3 * FL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
